// File: rtl/bcd_timekeeper.sv
`default_nettype none
// ============================================================================
// Module   : bcd_timekeeper
// Purpose  : BCD time-of-day counter (hh:mm[:ss]) with prescaler, validated
//            parallel load, 12/24h display, day-carry and alarm-match pulses.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_timekeeper #(
  parameter int SECONDS_EN = 1,
  parameter int PRESCALE   = 0,
  parameter int PS_W       = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       tick,
  input  logic       mode_12h,
  input  logic       load,
  input  logic [3:0] ld_hour_ms,
  input  logic [3:0] ld_hour_ls,
  input  logic [3:0] ld_min_ms,
  input  logic [3:0] ld_min_ls,
  input  logic [3:0] ld_sec_ms,
  input  logic [3:0] ld_sec_ls,
  input  logic       alarm_en,
  input  logic [3:0] al_hour_ms,
  input  logic [3:0] al_hour_ls,
  input  logic [3:0] al_min_ms,
  input  logic [3:0] al_min_ls,
  output logic [3:0] hour_ms,
  output logic [3:0] hour_ls,
  output logic [3:0] min_ms,
  output logic [3:0] min_ls,
  output logic [3:0] sec_ms,
  output logic [3:0] sec_ls,
  output logic       pm,
  output logic       day_carry,
  output logic       alarm_hit,
  output logic       load_err
);

  logic [3:0] hour_ms_q, hour_ls_q, min_ms_q, min_ls_q, sec_ms_q, sec_ls_q;
  logic [3:0] hour_ms_d, hour_ls_d, min_ms_d, min_ls_d, sec_ms_d, sec_ls_d;
  logic       day_carry_q, alarm_hit_q, load_err_q;
  logic       day_carry_d, alarm_hit_d, load_err_d;
  logic [3:0] inc_hm, inc_hl, inc_mm, inc_ml, inc_sm, inc_sl;
  logic       inc_wrap, c_min, c_hour;
  logic       adv, ld_ok, load_ok, al_ok;
  logic [4:0] hour_bin, hour_12;

  // Load is rejected unless it is a legal 24h time; seconds only matter when counted.
  assign ld_ok = (ld_hour_ms < 4'd2 ? ld_hour_ls <= 4'd9 :
                  ld_hour_ms == 4'd2 && ld_hour_ls <= 4'd3) &&
                 ld_min_ms <= 4'd5 && ld_min_ls <= 4'd9 &&
                 ((SECONDS_EN == 0) || (ld_sec_ms <= 4'd5 && ld_sec_ls <= 4'd9));
  assign load_ok = load & ld_ok;
  // A malformed alarm setting must never match any time.
  assign al_ok = (al_hour_ms < 4'd2 ? al_hour_ls <= 4'd9 :
                  al_hour_ms == 4'd2 && al_hour_ls <= 4'd3) &&
                 al_min_ms <= 4'd5 && al_min_ls <= 4'd9;

  generate
    if (PRESCALE == 0) begin : g_ext_tick
      assign adv = tick & en;
    end else begin : g_prescale
      localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
      logic [PS_W-1:0] ps_q, ps_d;
      assign adv = en && (ps_q == PS_LAST);
      // Prescaler counts enabled cycles; an accepted load restarts the interval.
      always_comb begin
        ps_d = ps_q;
        if (load_ok)        ps_d = '0;
        else if (en && adv) ps_d = '0;
        else if (en)        ps_d = ps_q + 1'b1;
      end
      // Prescaler register.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ps_q <= '0;
        else        ps_q <= ps_d;
      end
    end
  endgenerate

  // Ripple-carry successor of the current time (used only when adv is taken).
  always_comb begin
    inc_sl   = sec_ls_q;
    inc_sm   = sec_ms_q;
    inc_ml   = min_ls_q;
    inc_mm   = min_ms_q;
    inc_hl   = hour_ls_q;
    inc_hm   = hour_ms_q;
    inc_wrap = 1'b0;
    c_min    = 1'b1;
    c_hour   = 1'b0;
    if (SECONDS_EN != 0) begin
      c_min = 1'b0;
      if (sec_ls_q == 4'd9) begin
        inc_sl = 4'd0;
        if (sec_ms_q == 4'd5) begin
          inc_sm = 4'd0;
          c_min  = 1'b1;
        end else begin
          inc_sm = sec_ms_q + 4'd1;
        end
      end else begin
        inc_sl = sec_ls_q + 4'd1;
      end
    end
    if (c_min) begin
      if (min_ls_q == 4'd9) begin
        inc_ml = 4'd0;
        if (min_ms_q == 4'd5) begin
          inc_mm = 4'd0;
          c_hour = 1'b1;
        end else begin
          inc_mm = min_ms_q + 4'd1;
        end
      end else begin
        inc_ml = min_ls_q + 4'd1;
      end
    end
    if (c_hour) begin
      if (hour_ms_q == 4'd2 && hour_ls_q == 4'd3) begin
        inc_hm   = 4'd0;
        inc_hl   = 4'd0;
        inc_wrap = 1'b1;
      end else if (hour_ls_q == 4'd9) begin
        inc_hl = 4'd0;
        inc_hm = hour_ms_q + 4'd1;
      end else begin
        inc_hl = hour_ls_q + 4'd1;
      end
    end
  end

  // Next-state select: load beats adv (even a rejected load swallows the adv).
  always_comb begin
    hour_ms_d   = hour_ms_q;
    hour_ls_d   = hour_ls_q;
    min_ms_d    = min_ms_q;
    min_ls_d    = min_ls_q;
    sec_ms_d    = sec_ms_q;
    sec_ls_d    = sec_ls_q;
    day_carry_d = 1'b0;
    alarm_hit_d = 1'b0;
    load_err_d  = 1'b0;
    if (load) begin
      if (ld_ok) begin
        hour_ms_d = ld_hour_ms;
        hour_ls_d = ld_hour_ls;
        min_ms_d  = ld_min_ms;
        min_ls_d  = ld_min_ls;
        sec_ms_d  = (SECONDS_EN != 0) ? ld_sec_ms : 4'd0;
        sec_ls_d  = (SECONDS_EN != 0) ? ld_sec_ls : 4'd0;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (adv) begin
      hour_ms_d   = inc_hm;
      hour_ls_d   = inc_hl;
      min_ms_d    = inc_mm;
      min_ls_d    = inc_ml;
      sec_ms_d    = inc_sm;
      sec_ls_d    = inc_sl;
      day_carry_d = inc_wrap;
      alarm_hit_d = alarm_en && al_ok && inc_sm == 4'd0 && inc_sl == 4'd0 &&
                    inc_hm == al_hour_ms && inc_hl == al_hour_ls &&
                    inc_mm == al_min_ms && inc_ml == al_min_ls;
    end
  end

  // Time and pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hour_ms_q   <= 4'd0;
      hour_ls_q   <= 4'd0;
      min_ms_q    <= 4'd0;
      min_ls_q    <= 4'd0;
      sec_ms_q    <= 4'd0;
      sec_ls_q    <= 4'd0;
      day_carry_q <= 1'b0;
      alarm_hit_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      hour_ms_q   <= hour_ms_d;
      hour_ls_q   <= hour_ls_d;
      min_ms_q    <= min_ms_d;
      min_ls_q    <= min_ls_d;
      sec_ms_q    <= sec_ms_d;
      sec_ls_q    <= sec_ls_d;
      day_carry_q <= day_carry_d;
      alarm_hit_q <= alarm_hit_d;
      load_err_q  <= load_err_d;
    end
  end

  // Hour display: 12h folding is purely cosmetic and never touches the count.
  always_comb begin
    hour_bin = 5'(hour_ms_q) * 5'd10 + 5'(hour_ls_q);
    pm       = (hour_bin >= 5'd12);
    hour_12  = hour_bin;
    if (hour_bin == 5'd0)       hour_12 = 5'd12;
    else if (hour_bin > 5'd12)  hour_12 = hour_bin - 5'd12;
    if (mode_12h) begin
      if (hour_12 >= 5'd10) begin
        hour_ms = 4'd1;
        hour_ls = 4'(hour_12 - 5'd10);
      end else begin
        hour_ms = 4'd0;
        hour_ls = hour_12[3:0];
      end
    end else begin
      hour_ms = hour_ms_q;
      hour_ls = hour_ls_q;
    end
  end

  assign min_ms    = min_ms_q;
  assign min_ls    = min_ls_q;
  assign sec_ms    = sec_ms_q;
  assign sec_ls    = sec_ls_q;
  assign day_carry = day_carry_q;
  assign alarm_hit = alarm_hit_q;
  assign load_err  = load_err_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_timekeeper.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_bcd_timekeeper
// Purpose  : Scoreboard bench for bcd_timekeeper. DUT A: hh:mm:ss, external
//            tick. DUT B: hh:mm, internal prescale of 4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_timekeeper;

  typedef struct packed {
    logic       en, tick, mode_12h, load;
    logic [3:0] ld_hm, ld_hl, ld_mm, ld_ml, ld_sm, ld_sl;
    logic       alarm_en;
    logic [3:0] al_hm, al_hl, al_mm, al_ml;
  } in_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  in_t  ia, ib;

  logic [3:0] a_hm, a_hl, a_mm, a_ml, a_sm, a_sl;
  logic       a_pm, a_dc, a_ah, a_le;
  logic [3:0] b_hm, b_hl, b_mm, b_ml, b_sm, b_sl;
  logic       b_pm, b_dc, b_ah, b_le;
  logic [27:0] a_vec, b_vec;
  assign a_vec = {a_hm, a_hl, a_mm, a_ml, a_sm, a_sl, a_pm, a_dc, a_ah, a_le};
  assign b_vec = {b_hm, b_hl, b_mm, b_ml, b_sm, b_sl, b_pm, b_dc, b_ah, b_le};

  bcd_timekeeper #(.SECONDS_EN(1), .PRESCALE(0), .PS_W(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(ia.en), .tick(ia.tick), .mode_12h(ia.mode_12h),
    .load(ia.load), .ld_hour_ms(ia.ld_hm), .ld_hour_ls(ia.ld_hl), .ld_min_ms(ia.ld_mm),
    .ld_min_ls(ia.ld_ml), .ld_sec_ms(ia.ld_sm), .ld_sec_ls(ia.ld_sl),
    .alarm_en(ia.alarm_en), .al_hour_ms(ia.al_hm), .al_hour_ls(ia.al_hl),
    .al_min_ms(ia.al_mm), .al_min_ls(ia.al_ml),
    .hour_ms(a_hm), .hour_ls(a_hl), .min_ms(a_mm), .min_ls(a_ml), .sec_ms(a_sm),
    .sec_ls(a_sl), .pm(a_pm), .day_carry(a_dc), .alarm_hit(a_ah), .load_err(a_le));

  bcd_timekeeper #(.SECONDS_EN(0), .PRESCALE(4), .PS_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(ib.en), .tick(ib.tick), .mode_12h(ib.mode_12h),
    .load(ib.load), .ld_hour_ms(ib.ld_hm), .ld_hour_ls(ib.ld_hl), .ld_min_ms(ib.ld_mm),
    .ld_min_ls(ib.ld_ml), .ld_sec_ms(ib.ld_sm), .ld_sec_ls(ib.ld_sl),
    .alarm_en(ib.alarm_en), .al_hour_ms(ib.al_hm), .al_hour_ls(ib.al_hl),
    .al_min_ms(ib.al_mm), .al_min_ls(ib.al_ml),
    .hour_ms(b_hm), .hour_ls(b_hl), .min_ms(b_mm), .min_ls(b_ml), .sec_ms(b_sm),
    .sec_ls(b_sl), .pm(b_pm), .day_carry(b_dc), .alarm_hit(b_ah), .load_err(b_le));

  initial forever #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  logic [27:0] qa[$], qb[$];
  string       qtag[$];
  // Reference model state: time as seconds-of-day, prescaler as enabled-cycle count.
  int ta = 0, psa = 0, tb = 0, psb = 0;

  task automatic check(input string name, input logic [27:0] act, input logic [27:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [27:0] disp(input int t, input logic m12, input logic dc,
                                       input logic ah, input logic le);
    int h, m, s, dh;
    h = t / 3600; m = (t / 60) % 60; s = t % 60;
    dh = h;
    if (m12) dh = (h % 12 == 0) ? 12 : h % 12;
    return {4'(dh / 10), 4'(dh % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10),
            (h >= 12), dc, ah, le};
  endfunction

  function automatic int alarm_secs(input in_t i);
    int h, m;
    h = i.al_hm * 10 + i.al_hl;
    m = i.al_mm * 10 + i.al_ml;
    return h * 3600 + m * 60;
  endfunction

  task automatic model_step(input in_t i, input int se, input int ps,
                            inout int t, inout int psc, output logic [27:0] e);
    logic adv, ok, dc, ah, le, alv;
    int h, m, s;
    dc = 0; ah = 0; le = 0;
    if (ps == 0) adv = i.en && i.tick;
    else begin
      adv = 0;
      if (i.en) begin
        psc++;
        if (psc == ps) begin adv = 1; psc = 0; end
      end
    end
    if (i.load) begin
      h = i.ld_hm * 10 + i.ld_hl;
      m = i.ld_mm * 10 + i.ld_ml;
      s = i.ld_sm * 10 + i.ld_sl;
      ok = i.ld_hm <= 9 && i.ld_hl <= 9 && i.ld_mm <= 5 && i.ld_ml <= 9 && h <= 23;
      if (se != 0) ok = ok && i.ld_sm <= 5 && i.ld_sl <= 9;
      if (ok) begin
        t = h * 3600 + m * 60 + ((se != 0) ? s : 0);
        psc = 0;
      end else le = 1;
    end else if (adv) begin
      t = (t + ((se != 0) ? 1 : 60)) % 86400;
      dc = (t == 0);
      alv = i.al_hm <= 9 && i.al_hl <= 9 && i.al_mm <= 5 && i.al_ml <= 9 &&
            (i.al_hm * 10 + i.al_hl) <= 23;
      ah = i.alarm_en && alv && (t == alarm_secs(i));
    end
    e = disp(t, i.mode_12h, dc, ah, le);
  endtask

  function automatic in_t ld_raw(input in_t i, input logic [3:0] hm, hl, mm, ml, sm, sl);
    in_t r;
    r = i; r.load = 1;
    r.ld_hm = hm; r.ld_hl = hl; r.ld_mm = mm; r.ld_ml = ml; r.ld_sm = sm; r.ld_sl = sl;
    return r;
  endfunction

  function automatic in_t ld_t(input in_t i, input int t);
    int h, m, s;
    h = t / 3600; m = (t / 60) % 60; s = t % 60;
    return ld_raw(i, 4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10));
  endfunction

  // Random load: garbage digits, just before the alarm, just before midnight, or anywhere.
  function automatic in_t rand_load(input in_t i, input int unit);
    int t;
    case ($urandom_range(0, 3))
      0: return ld_raw(i, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                       4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                       4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      1: t = alarm_secs(i) - unit * int'($urandom_range(1, 3));
      2: t = 86400 - unit * int'($urandom_range(1, 3));
      default: t = int'($urandom_range(0, 86399));
    endcase
    t = ((t % 86400) + 86400) % 86400;
    return ld_t(i, t);
  endfunction

  function automatic in_t rand_alarm(input in_t i);
    in_t r;
    int t;
    r = i;
    t = int'($urandom_range(0, 1439)) * 60;
    r.alarm_en = ($urandom_range(0, 3) != 0);
    r.al_hm = 4'(t / 36000); r.al_hl = 4'((t / 3600) % 10);
    r.al_mm = 4'((t / 600) % 6); r.al_ml = 4'((t / 60) % 10);
    if ($urandom_range(0, 7) == 0) r.al_mm = 4'($urandom_range(6, 15));
    return r;
  endfunction

  // Issue one clock of stimulus: predicted post-edge outputs go to the scoreboard.
  task automatic step(input string tag);
    logic [27:0] e;
    model_step(ia, 1, 0, ta, psa, e); qa.push_back(e);
    model_step(ib, 0, 4, tb, psb, e); qb.push_back(e);
    qtag.push_back(tag);
    @(posedge clk); #2;
    ia.tick = 0; ia.load = 0; ib.tick = 0; ib.load = 0;
  endtask

  task automatic do_reset();
    rst_n = 0; #1;
    ta = 0; psa = 0; tb = 0; psb = 0;
    check("reset/A", a_vec, disp(0, ia.mode_12h, 0, 0, 0));
    check("reset/B", b_vec, disp(0, ib.mode_12h, 0, 0, 0));
    @(posedge clk); #2;
    rst_n = 1;
  endtask

  // Monitor: one scoreboard entry is due after every stimulus edge.
  initial begin
    string tg;
    forever begin
      @(posedge clk); #1;
      if (qa.size() > 0) begin
        tg = qtag.pop_front();
        check({tg, "/A"}, a_vec, qa.pop_front());
        check({tg, "/B"}, b_vec, qb.pop_front());
      end
    end
  end

  initial begin
    ia = '0; ib = '0;
    #3;
    do_reset();

    // DUT A directed
    ia.en = 1;
    repeat (3) begin ia.tick = 1; step("tick3"); end
    ia = ld_t(ia, 9 * 60 + 59);             step("ld000959");
    ia.tick = 1;                            step("roll001000");
    ia = ld_t(ia, 86399);                   step("ld235959");
    ia.tick = 1;                            step("daywrap");
    step("dc_clear");
    ia.mode_12h = 1;                        step("midnight_12h");
    ia = ld_t(ia, 13 * 3600 + 5 * 60);      step("ld1305_12h");
    ia.mode_12h = 0;                        step("h13_24h");
    ia.mode_12h = 1; ia = ld_t(ia, 12 * 3600); step("noon_12h");
    ia.mode_12h = 0;
    ia = ld_raw(ia, 2, 4, 0, 0, 0, 0);      step("bad_h24");
    ia = ld_raw(ia, 0, 1, 6, 0, 0, 0);      step("bad_mm6");
    ia = ld_raw(ia, 0, 1, 0, 4'hA, 0, 0);   step("bad_digA");
    ia = ld_raw(ia, 0, 1, 0, 0, 6, 0);      step("bad_ss6");
    step("err_clear");
    ia = ld_t(ia, 10 * 3600); ia.tick = 1;  step("ld_and_tick");
    ia = ld_raw(ia, 3, 0, 0, 0, 0, 0); ia.tick = 1; step("badld_and_tick");
    ia.tick = 1;                            step("tick_after");
    ia.alarm_en = 1; ia.al_hm = 0; ia.al_hl = 7; ia.al_mm = 3; ia.al_ml = 0;
    ia = ld_t(ia, 7 * 3600 + 29 * 60 + 59); step("ld072959");
    ia.tick = 1;                            step("alarm_hit");
    step("alarm_clear");
    ia = ld_t(ia, 7 * 3600 + 30 * 60);      step("ld_at_alarm");
    ia.alarm_en = 0;
    ia = ld_t(ia, 7 * 3600 + 29 * 60 + 59); step("ld072959b");
    ia.tick = 1;                            step("alarm_disabled");
    ia.en = 0; ia.tick = 1;                 step("tick_no_en");

    // DUT B directed
    ib.en = 1;
    repeat (12) step("ps_run");
    ib.en = 0;
    repeat (5) step("ps_hold");
    ib.en = 1;
    repeat (2) step("ps_partial");
    do_reset();
    repeat (4) step("ps_restart");

    // Randomized traffic on both
    for (int n = 0; n < 1500; n++) begin
      ia.en = ($urandom_range(0, 3) != 0);
      ia.tick = 1'($urandom_range(0, 1));
      ib.en = ($urandom_range(0, 3) != 0);
      ib.tick = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 31) == 0) ia.mode_12h = ~ia.mode_12h;
      if ($urandom_range(0, 31) == 0) ib.mode_12h = ~ib.mode_12h;
      if ($urandom_range(0, 63) == 0) ia = rand_alarm(ia);
      if ($urandom_range(0, 63) == 0) ib = rand_alarm(ib);
      if ($urandom_range(0, 15) == 0) ia = rand_load(ia, 1);
      if ($urandom_range(0, 15) == 0) ib = rand_load(ib, 60);
      if (n == 750) do_reset();
      step("rand");
    end

    repeat (2) @(posedge clk);
    #2;
    check("drain", 28'(qa.size()), 28'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bcd_timekeeper.md
Name: bcd_timekeeper

Overview:
- Synchronous BCD time-of-day counter (hours:minutes[:seconds]); next generation of the team's ripple-carry BCD minute adder.
- Adds an optional seconds stage, an internal prescaler, validated parallel load, 12/24-hour display mode, day-carry output and an alarm-match pulse.
- Sits between the board timebase and the 7-segment/display driver; the alarm pulse feeds the buzzer controller.

Parameters:
- SECONDS_EN, 1, 1 = hh:mm:ss counting; 0 = hh:mm only (each advance adds one minute, sec outputs tied 0).
- PRESCALE, 0, 0 = advance on the external tick input; N>0 = internal advance every N clk cycles while en=1 (tick ignored).
- PS_W, 32, prescaler counter width; must hold PRESCALE-1.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  count enable; gates tick and the prescaler.
- tick  input  1  single-cycle advance request (used only when PRESCALE=0).
- mode_12h  input  1  0 = 24h hour display, 1 = 12h hour display.
- load  input  1  single-cycle parallel-load strobe.
- ld_hour_ms, ld_hour_ls, ld_min_ms, ld_min_ls, ld_sec_ms, ld_sec_ls  input  4 each  load value, 24h BCD.
- alarm_en  input  1  alarm compare enable.
- al_hour_ms, al_hour_ls, al_min_ms, al_min_ls  input  4 each  alarm time, 24h BCD.
- hour_ms, hour_ls  output  4 each  display hour (24h or 12h per mode_12h).
- min_ms, min_ls, sec_ms, sec_ls  output  4 each  current time digits.
- pm  output  1  1 when the internal hour is 12..23; valid in both modes.
- day_carry  output  1  1-cycle pulse on 23:59:59 -> 00:00:00 (23:59 -> 00:00 if SECONDS_EN=0).
- alarm_hit  output  1  1-cycle pulse on alarm match.
- load_err  output  1  1-cycle pulse when a load is rejected.

Behaviour:
- Internal state: six 4-bit BCD registers holding 24h time. Reset (async, rst_n=0): all 00:00:00; day_carry, alarm_hit, load_err = 0; prescaler = 0.
- Advance event (adv):
  - PRESCALE=0: adv = tick & en.
  - PRESCALE>0: counter increments while en=1; adv fires on the cycle the counter equals PRESCALE-1, and the counter returns to 0. en=0 holds the counter.
- On adv, the registered update takes effect next edge (1-cycle latency). Ripple:
  - sec_ls 9->0 carries into sec_ms; sec_ms 5->0 carries into min_ls.
  - min_ls 9->0 carries into min_ms; min_ms 5->0 carries into the hour.
  - Hour: ls 9->0 with ms+1; 23 -> 00 and asserts day_carry the same edge.
  - SECONDS_EN=0: sec registers are fixed at 0 and adv enters at min_ls.
- Load:
  - Accepted only if every digit is <=9, min_ms<=5, sec_ms<=5, and hour<=23. When SECONDS_EN=0, sec inputs are ignored and not checked.
  - Accepted load: registers take the load value next edge and the prescaler clears to 0.
  - Rejected load: state unchanged; load_err pulses 1 cycle.
  - load and adv in the same cycle: load wins and the adv is dropped, even when the load is rejected. No day_carry or alarm_hit is generated by a load.
- 12h display (mode_12h=1), combinational from state:
  - Internal 00 -> 12 (pm=0); 01..11 -> unchanged (pm=0); 12 -> 12 (pm=1); 13..23 -> 01..11 (pm=1).
  - Mode changes take effect immediately with no effect on count.
  - mode_12h=0: hour outputs equal the internal registers.
- alarm_hit:
  - Registered 1-cycle pulse, asserted on the edge where an adv moves the time into hh:mm == alarm time with seconds == 00 (minute boundary), alarm_en=1.
  - Alarm values that are not valid BCD never match.
- Reset asserted mid-operation clears everything immediately, including pending pulses.
- All outputs other than the hour digits and pm are direct register outputs.

Test Plan:
- Reset, SECONDS_EN=1, PRESCALE=0: 3 ticks -> 00:00:03; load 00:09:59 then tick -> 00:10:00 one cycle after the tick.
- Load 23:59:59, tick -> 00:00:00 with day_carry high exactly one cycle; 12h mode shows 12:00:00 pm=0.
- Load 13:05:00, mode_12h=1 -> hour 01 pm=1; mode_12h=0 -> hour 13 pm=1. Load 12:00:00 in 12h mode -> hour 12 pm=1.
- Load hour 24, min_ms 6 or digit 0xA -> load_err pulse, time unchanged. load and tick in the same cycle with 10:00:00 -> 10:00:00, no increment.
- Alarm 07:30, alarm_en=1, load 07:29:59, tick -> 07:30:00 with alarm_hit one pulse. Load 07:30:00 directly -> no alarm_hit. alarm_en=0 -> no pulse.
- PRESCALE=4, SECONDS_EN=0, en=1 for 12 clk -> 00:03; drop en for 5 clk -> hold. Assert rst_n=0 mid-count -> 00:00 asynchronously, prescaler restarts.
